alu_seq: RTL and testbench

- Parametrised, handshaked ALU that generalises the single-cycle datapath ALU.
- Adds XOR, signed/unsigned compare, shifts and an iterative multiply/divide unit.
- Sits between the decode and writeback stages of the multi-cycle/pipelined core.
- Single-cycle ops complete in 1 cycle; mul/div ops take WIDTH+1 cycles.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_mul_div.sv | 123 ++++++++++++
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the op-code width.
// Used by alu_seq and, when ALU_SEQ_MULDIV_EN is defined, by mul_div_unit.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REM   = 4'd14,
        OP_REMU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul_div.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Only built when ALU_SEQ_MULDIV_EN is defined; start loads operands, done marks the final step.
`ifdef ALU_SEQ_MULDIV_EN
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_op_e          op_reg;
    logic             busy_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] opnd_reg;   // multiplicand, or divisor magnitude
    logic [WIDTH-1:0] acc_reg;    // product high half, or partial remainder
    logic [WIDTH-1:0] lo_reg;     // product low half, or dividend/quotient
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             dz_reg;

    alu_op_e          op_in;
    logic             is_signed_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        op_in         = alu_op_e'(op);
        is_signed_div = (op_in == OP_DIV) || (op_in == OP_REM);
        mag_a         = (is_signed_div && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b         = (is_signed_div && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    logic             is_mul;
    logic [WIDTH:0]   sum_mul;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] lo_next;

    always_comb begin
        is_mul   = (op_reg == OP_MUL) || (op_reg == OP_MULHU);
        sum_mul  = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        shifted  = {acc_reg, lo_reg[WIDTH-1]};
        trial    = shifted - {1'b0, opnd_reg};
        acc_next = acc_reg;
        lo_next  = lo_reg;
        if (is_mul) begin
            {acc_next, lo_next} = {sum_mul, lo_reg[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_next = trial[WIDTH-1:0];
            lo_next  = {lo_reg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = shifted[WIDTH-1:0];
            lo_next  = {lo_reg[WIDTH-2:0], 1'b0};
        end
    end

    // Result is taken from the final step's next values so it lands on the same edge.
    // A zero divisor leaves |a| in the remainder, so the sign fix-up already restores src_a.
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        quo_fix = neg_q_reg ? -lo_next : lo_next;
        rem_fix = neg_r_reg ? -acc_next : acc_next;
        case (op_reg)
            OP_MUL:          result = lo_next;
            OP_MULHU:        result = acc_next;
            OP_DIV, OP_DIVU: result = dz_reg ? '1 : quo_fix;
            default:         result = rem_fix;
        endcase
    end

    assign done = busy_reg && (count_reg == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg    <= OP_MUL;
            busy_reg  <= 1'b0;
            count_reg <= '0;
            opnd_reg  <= '0;
            acc_reg   <= '0;
            lo_reg    <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            dz_reg    <= 1'b0;
        end else if (start) begin
            op_reg    <= op_in;
            busy_reg  <= 1'b1;
            count_reg <= CW'(WIDTH);
            acc_reg   <= '0;
            dz_reg    <= (src_b == '0);
            neg_q_reg <= is_signed_div && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r_reg <= is_signed_div && src_a[WIDTH-1];
            if ((op_in == OP_MUL) || (op_in == OP_MULHU)) begin
                opnd_reg <= src_a;
                lo_reg   <= src_b;
            end else begin
                opnd_reg <= mag_b;
                lo_reg   <= mag_a;
            end
        end else if (busy_reg) begin
            acc_reg   <= acc_next;
            lo_reg    <= lo_next;
            count_reg <= count_reg - CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus optional iterative mul/div (macro ALU_SEQ_MULDIV_EN).
// Without the macro, ops 10-15 finish in one cycle with result 0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_reg;
    alu_op_e          op_e;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             is_muldiv;

    always_comb begin
        op_e      = alu_op_e'(op);
        shamt     = src_b[SHW-1:0];
        is_muldiv = (op >= OP_W'(10));
        case (op_e)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign md_start = (state_reg == IDLE) && in_valid && is_muldiv;

    mul_div_unit #(
        .WIDTH(WIDTH)
    ) u_mul_div (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .done   (md_done),
        .result (md_result)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_muldiv) begin
`ifdef ALU_SEQ_MULDIV_EN
                            state_reg <= BUSY;
`else
                            result    <= '0;
                            zero      <= 1'b1;
                            out_valid <= 1'b1;
                            state_reg <= DONE;
`endif
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (md_done) begin
                        result    <= md_result;
                        zero      <= (md_result == '0);
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end
`else
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against a reference model,
// backpressure and mid-operation reset. Expectations follow ALU_SEQ_MULDIV_EN when defined.
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int failures = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        int sh;
        p  = {32'd0, a} * {32'd0, b};
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b % 32);
        if (o >= 4'd10 && !MD) return 32'd0;
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return 32'($signed(a) >>> sh);
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] o);
        return (o >= 4'd10 && MD) ? 33 : 1;
    endfunction

    // Drive one request; inputs are scrambled right after the accept edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int lat;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s in_ready before issue: got %b want 1", tag, in_ready);
            failures++;
        end
        checks++;
        issue(o, a, b);
        wait_out(lat);
        $display("op=%0d a=%h b=%h -> result=%h zero=%b lat=%0d", o, a, b, result, zero, lat);
        if (result !== exp) begin
            $display("FAIL %s result: got %h want %h", tag, result, exp);
            failures++;
        end
        checks++;
        if (zero !== (exp == 0)) begin
            $display("FAIL %s zero: got %b want %b", tag, zero, (exp == 0));
            failures++;
        end
        checks++;
        if (lat != ref_lat(o)) begin
            $display("FAIL %s latency: got %0d want %0d", tag, lat, ref_lat(o));
            failures++;
        end
        checks++;
        release_out();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (in_ready !== 1'b1) begin $display("FAIL reset in_ready: got %b want 1", in_ready); failures++; end
        checks++;
        if (out_valid !== 1'b0) begin $display("FAIL reset out_valid: got %b want 0", out_valid); failures++; end
        checks++;
        if (result !== 32'd0) begin $display("FAIL reset result: got %h want 0", result); failures++; end
        checks++;
        if (zero !== 1'b1) begin $display("FAIL reset zero: got %b want 1", zero); failures++; end
        checks++;
    endtask

    typedef struct {
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    task automatic test_directed();
        vec_t v[20];
        logic [31:0] exp;
        v[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        v[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        v[2]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        v[3]  = '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        v[4]  = '{4'd9,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000};
        v[5]  = '{4'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
        v[6]  = '{4'd7,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        v[7]  = '{4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        v[8]  = '{4'd10, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF};
        v[9]  = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[10] = '{4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        v[11] = '{4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        v[12] = '{4'd13, 32'h0000_000A, 32'h0000_0000, 32'hFFFF_FFFF};
        v[13] = '{4'd15, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A};
        v[14] = '{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[15] = '{4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        v[16] = '{4'd12, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
        v[17] = '{4'd14, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
        v[18] = '{4'd10, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C};
        v[19] = '{4'd12, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        for (int i = 0; i < 20; i++) begin
            exp = (v[i].o >= 4'd10 && !MD) ? 32'd0 : v[i].e;
            run_one($sformatf("directed%0d", i), v[i].o, v[i].a, v[i].b, exp);
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 40));
                default: ;
            endcase
            run_one($sformatf("random%0d", i), o, a, b, ref_alu(o, a, b));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int lat;
        bit seen;
        a = $urandom;
        b = $urandom;
        exp = a - b;
        issue(4'd1, a, b);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 4'd0;
            src_a = $urandom;
            src_b = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            $display("backpressure cycle %0d: result=%h zero=%b in_ready=%b out_valid=%b", c, result, zero, in_ready, out_valid);
            if (result !== exp) begin $display("FAIL bp_result: got %h want %h", result, exp); failures++; end
            checks++;
            if (zero !== (exp == 0)) begin $display("FAIL bp_zero: got %b want %b", zero, (exp == 0)); failures++; end
            checks++;
            if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready: got %b want 0", in_ready); failures++; end
            checks++;
            if (out_valid !== 1'b1) begin $display("FAIL bp_out_valid: got %b want 1", out_valid); failures++; end
            checks++;
        end
        release_out();
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL bp_return_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
            failures++;
        end
        checks++;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        if (seen) begin $display("FAIL bp_ignored_requests: got out_valid=1 want 0"); failures++; end
        checks++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(4'd13, $urandom, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        $display("reset mid-DIVU: in_ready=%b out_valid=%b result=%h zero=%b", in_ready, out_valid, result, zero);
        if (out_valid !== 1'b0) begin $display("FAIL midreset_out_valid: got %b want 0", out_valid); failures++; end
        checks++;
        if (in_ready !== 1'b1) begin $display("FAIL midreset_in_ready: got %b want 1", in_ready); failures++; end
        checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            $display("FAIL midreset_result: got %h/%b want 0/1", result, zero);
            failures++;
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        if (seen) begin $display("FAIL midreset_stale: got out_valid=1 want 0"); failures++; end
        checks++;
        run_one("post_reset_add", 4'd0, 32'd2, 32'd3, 32'd5);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
